// File: rtl/mem_loader_if.sv
// Bundles the stream, memory and traversal handshakes of mem_loader.
// master = loader side, slave = stream source / memory_unit / mem_traversal side.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 8
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

interface mem_loader_if #(
    parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
    parameter int DATA_W = `MEMORY_DATA_WIDTH
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    logic [1:0]        mem_func;
    logic              mem_execute;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;

    logic [ADDR_W-1:0] trav_start_addr;
    logic              trav_execute;
    logic              trav_finished;

    modport master (
        input  in_valid, in_data, in_last, read_data, mem_ready, trav_finished,
        output in_ready, mem_func, mem_execute, address, write_data,
               trav_start_addr, trav_execute
    );

    modport slave (
        output in_valid, in_data, in_last, read_data, mem_ready, trav_finished,
        input  in_ready, mem_func, mem_execute, address, write_data,
               trav_start_addr, trav_execute
    );
endinterface

// File: rtl/mem_loader.sv
// Streams a noun image into memory_unit, then runs mem_traversal on it.
// Optional read-back verification of every word: define MEM_LOADER_VERIFY_EN.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 8
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module mem_loader #(
    parameter int                ADDR_W     = `MEMORY_ADDR_WIDTH,
    parameter int                DATA_W     = `MEMORY_DATA_WIDTH,
    parameter logic [1:0]        FUNC_WRITE = 2'b01,
    parameter logic [1:0]        FUNC_READ  = 2'b00,
    parameter logic [ADDR_W-1:0] MAX_ADDR   = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    mem_loader_if.master      bus,
    output logic [ADDR_W-1:0] words_loaded,
    output logic              busy,
    output logic              finished,
    output logic              error
);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_WORD,
        WR_ISSUE,
        WR_ACK,
        WR_DONE,
`ifdef MEM_LOADER_VERIFY_EN
        RD_ISSUE,
        RD_ACK,
        RD_DONE,
        CMP,
`endif
        NEXT,
        RUN,
        DONE,
        ERROR
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, trav_addr_q, count_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        func_q;
    logic              last_q, error_q;

    logic load, accept, incr, advance, set_err, issue, ready_c, run_c, done_c;
`ifdef MEM_LOADER_VERIFY_EN
    logic rd_setup;
`else
    logic unused_read;
    assign unused_read = ^{bus.read_data, FUNC_READ};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (power) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        accept  = 1'b0;
        incr    = 1'b0;
        advance = 1'b0;
        set_err = 1'b0;
        issue   = 1'b0;
        ready_c = 1'b0;
        run_c   = 1'b0;
        done_c  = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
        rd_setup = 1'b0;
`endif
        case (state)
            IDLE, ERROR: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                ready_c = bus.mem_ready;
                if (bus.in_valid && bus.mem_ready) begin
                    accept  = 1'b1;
                    state_n = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                issue   = 1'b1;
                state_n = WR_ACK;
            end
            WR_ACK: begin
                if (!bus.mem_ready) state_n = WR_DONE;
            end
            WR_DONE: begin
                if (bus.mem_ready) begin
`ifdef MEM_LOADER_VERIFY_EN
                    rd_setup = 1'b1;
                    state_n  = RD_ISSUE;
`else
                    incr    = 1'b1;
                    state_n = NEXT;
`endif
                end
            end
`ifdef MEM_LOADER_VERIFY_EN
            RD_ISSUE: begin
                issue   = 1'b1;
                state_n = RD_ACK;
            end
            RD_ACK: begin
                if (!bus.mem_ready) state_n = RD_DONE;
            end
            RD_DONE: begin
                if (bus.mem_ready) state_n = CMP;
            end
            CMP: begin
                if (bus.read_data != data_q) begin
                    set_err = 1'b1;
                    state_n = ERROR;
                end else begin
                    incr    = 1'b1;
                    state_n = NEXT;
                end
            end
`endif
            // Running off the top of memory is an error rather than a wrap to 0.
            NEXT: begin
                if (last_q) begin
                    state_n = RUN;
                end else if (addr_q == MAX_ADDR) begin
                    set_err = 1'b1;
                    state_n = ERROR;
                end else begin
                    advance = 1'b1;
                    state_n = WAIT_WORD;
                end
            end
            RUN: begin
                run_c = 1'b1;
                if (bus.trav_finished) state_n = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            trav_addr_q <= '0;
            count_q     <= '0;
            data_q      <= '0;
            func_q      <= '0;
            last_q      <= 1'b0;
            error_q     <= 1'b0;
        end else if (power) begin
            if (load) begin
                addr_q      <= base_addr;
                trav_addr_q <= base_addr;
                count_q     <= '0;
                error_q     <= 1'b0;
            end
            if (accept) begin
                data_q <= bus.in_data;
                last_q <= bus.in_last;
                func_q <= FUNC_WRITE;
            end
`ifdef MEM_LOADER_VERIFY_EN
            if (rd_setup) func_q <= FUNC_READ;
`endif
            if (incr && count_q != MAX_ADDR) count_q <= count_q + 1'b1;
            if (advance) addr_q <= addr_q + 1'b1;
            if (set_err) error_q <= 1'b1;
        end
    end

    // Power gates the two handshake strobes so a frozen loader neither accepts nor issues.
    assign bus.in_ready        = power & ready_c;
    assign bus.mem_execute     = power & issue;
    assign bus.mem_func        = func_q;
    assign bus.address         = addr_q;
    assign bus.write_data      = data_q;
    assign bus.trav_start_addr = trav_addr_q;
    assign bus.trav_execute    = run_c;

    assign words_loaded = count_q;
    assign busy         = (state != IDLE);
    assign finished     = done_c;
    assign error        = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: behavioural memory_unit and mem_traversal models,
// table-driven loads, randomized loads against an arithmetic reference, and corner sequences.
module tb_mem_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int MAXA   = (1 << ADDR_W) - 1;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              power = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] words_loaded;
    logic              busy, finished, error;

    mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .power       (power),
        .start       (start),
        .base_addr   (base_addr),
        .bus         (bus),
        .words_loaded(words_loaded),
        .busy        (busy),
        .finished    (finished),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Memory unit model: a strobe makes it busy for 1..3 cycles; reads may be corrupted on demand.
    logic [DATA_W-1:0] mem [0:MAXA];
    logic              mem_busy;
    int                busy_cnt;
    logic              mem_hold = 1'b0;
    int                rd_cnt;
    int                corrupt_at = -1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] wlog_addr [$];
    logic [DATA_W-1:0] wlog_data [$];

    assign bus.mem_ready = !mem_busy && !mem_hold;
    assign bus.read_data = rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_busy <= 1'b0;
            busy_cnt <= 0;
            rdata    <= '0;
            rd_cnt   <= 0;
        end else if (bus.mem_execute && !mem_busy) begin
            mem_busy <= 1'b1;
            busy_cnt <= int'($urandom_range(3, 1));
            if (bus.mem_func == 2'b01) begin
                mem[bus.address] <= bus.write_data;
                wlog_addr.push_back(bus.address);
                wlog_data.push_back(bus.write_data);
            end else begin
                rdata  <= (rd_cnt == corrupt_at) ? ~mem[bus.address] : mem[bus.address];
                rd_cnt <= rd_cnt + 1;
            end
        end else if (mem_busy) begin
            if (busy_cnt <= 1) mem_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Traversal model: reports finished trav_delay cycles into the run, or immediately if trav_pre.
    int   trav_delay = 0;
    logic trav_pre   = 1'b0;
    int   run_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) run_cnt <= 0;
        else if (bus.trav_execute) run_cnt <= run_cnt + 1;
        else run_cnt <= 0;
    end
    assign bus.trav_finished = trav_pre || (bus.trav_execute && run_cnt >= trav_delay);

    int exec_cnt = 0, fin_cnt = 0, trav_cyc = 0, rdy_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_execute)  exec_cnt++;
        if (finished)         fin_cnt++;
        if (bus.trav_execute) trav_cyc++;
        if (bus.in_ready)     rdy_cnt++;
    end

    int checks = 0, failures = 0;
    logic [DATA_W-1:0] stim_words [$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, ".busy"}, 64'(busy), 0);
        checkOutput({tag, ".finished"}, 64'(finished), 0);
        checkOutput({tag, ".error"}, 64'(error), 0);
        checkOutput({tag, ".words_loaded"}, 64'(words_loaded), 0);
        checkOutput({tag, ".in_ready"}, 64'(bus.in_ready), 0);
        checkOutput({tag, ".mem_execute"}, 64'(bus.mem_execute), 0);
        checkOutput({tag, ".mem_func"}, 64'(bus.mem_func), 0);
        checkOutput({tag, ".address"}, 64'(bus.address), 0);
        checkOutput({tag, ".write_data"}, 64'(bus.write_data), 0);
        checkOutput({tag, ".trav_start_addr"}, 64'(bus.trav_start_addr), 0);
        checkOutput({tag, ".trav_execute"}, 64'(bus.trav_execute), 0);
    endtask

    task automatic pulseStart(input int base);
        @(negedge clk);
        base_addr = ADDR_W'(base);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Presents one word from a negedge; returns at the negedge after acceptance.
    task automatic sendWord(input logic [DATA_W-1:0] data, input bit last, output bit ok);
        int t = 0;
        ok = 1'b0;
        bus.in_data  = data;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!ok && !error && t < 400) begin
            #1;
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b0;
        if (!ok && !error) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitDone(input string tag);
        int t = 0;
        while (busy && !error && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) checkOutput({tag, ".done_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Reference: words land at base, base+1, ... until MAX; overflow means error.
    function automatic void refModel(input int base, input int n, output int writes, output int wl, output bit err);
        int room = MAXA - base + 1;
        if (n <= room) begin
            writes = n;
            err    = 1'b0;
        end else begin
            writes = room;
            err    = 1'b1;
        end
        wl = (writes > MAXA) ? MAXA : writes;
    endfunction

    task automatic applyStimulus(input int base, input int n, input int delay, input bit pre,
                                 input int exp_words, input int exp_writes, input bit exp_err,
                                 input string tag);
        int wbase = wlog_addr.size();
        int e0 = exec_cnt, f0 = fin_cnt, t0 = trav_cyc;
        int bad = 0;
        int exp_exec;
        bit ok;
        trav_delay = delay;
        trav_pre   = pre;
        pulseStart(base);
        checkOutput({tag, ".start_error"}, 64'(error), 0);
        checkOutput({tag, ".start_busy"}, 64'(busy), 1);
        checkOutput({tag, ".start_words"}, 64'(words_loaded), 0);
        for (int i = 0; i < n; i++) begin
            sendWord(stim_words[i], i == n - 1, ok);
            if (!ok) break;
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        waitDone(tag);
`ifdef MEM_LOADER_VERIFY_EN
        exp_exec = 2 * exp_writes;
`else
        exp_exec = exp_writes;
`endif
        checkOutput({tag, ".writes"}, 64'(wlog_addr.size() - wbase), 64'(exp_writes));
        for (int i = wbase; i < wlog_addr.size(); i++) begin
            if (i - wbase >= stim_words.size() ||
                wlog_addr[i] !== ADDR_W'(base + i - wbase) ||
                wlog_data[i] !== stim_words[i - wbase]) bad++;
        end
        checkOutput({tag, ".write_order"}, 64'(bad), 0);
        checkOutput({tag, ".mem_execute"}, 64'(exec_cnt - e0), 64'(exp_exec));
        checkOutput({tag, ".words_loaded"}, 64'(words_loaded), 64'(exp_words));
        checkOutput({tag, ".error"}, 64'(error), 64'(exp_err));
        checkOutput({tag, ".busy"}, 64'(busy), 64'(exp_err));
        checkOutput({tag, ".trav_start_addr"}, 64'(bus.trav_start_addr), 64'(base));
        checkOutput({tag, ".finished"}, 64'(fin_cnt - f0), exp_err ? 0 : 1);
        checkOutput({tag, ".trav_cycles"}, 64'(trav_cyc - t0), exp_err ? 0 : (pre ? 1 : 64'(delay + 1)));
    endtask

    typedef struct {
        int    base;
        int    n;
        int    delay;
        bit    pre;
        int    exp_words;
        int    exp_writes;
        bit    exp_err;
        string tag;
    } vec_t;

    initial begin
        vec_t vecs [6];
        bit   ok;
        int   e0, r0, w0, f0;

        vecs[0] = '{1,        4,   2, 1'b0, 4,   4,   1'b0, "base1_4w"};
        vecs[1] = '{MAXA,     2,   0, 1'b0, 1,   1,   1'b1, "top_overflow"};
        vecs[2] = '{MAXA - 1, 2,   1, 1'b0, 2,   2,   1'b0, "top_fit"};
        vecs[3] = '{0,        1,   0, 1'b1, 1,   1,   1'b0, "one_word_prefin"};
        vecs[4] = '{MAXA - 2, 5,   0, 1'b0, 3,   3,   1'b1, "top_overflow3"};
        vecs[5] = '{0,        256, 0, 1'b0, 255, 256, 1'b0, "saturate"};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        #1;
        checkIdleZero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            stim_words.delete();
            for (int i = 0; i < vecs[v].n; i++) stim_words.push_back(DATA_W'(16'hA1 + i));
            applyStimulus(vecs[v].base, vecs[v].n, vecs[v].delay, vecs[v].pre,
                          vecs[v].exp_words, vecs[v].exp_writes, vecs[v].exp_err, vecs[v].tag);
        end

        for (int r = 0; r < 8; r++) begin
            int base, n, writes, wl;
            bit err;
            base = ($urandom_range(3, 0) == 0) ? MAXA - int'($urandom_range(3, 0)) : int'($urandom_range(MAXA, 0));
            n    = int'($urandom_range(6, 1));
            stim_words.delete();
            for (int i = 0; i < n; i++) stim_words.push_back(DATA_W'($urandom));
            refModel(base, n, writes, wl, err);
            applyStimulus(base, n, int'($urandom_range(3, 0)), 1'b0, wl, writes, err, $sformatf("rand%0d", r));
        end

        // Memory stays busy: the loader must not accept or issue anything.
        trav_pre = 1'b0;
        trav_delay = 1;
        mem_hold = 1'b1;
        pulseStart(5);
        e0 = exec_cnt; w0 = wlog_addr.size(); f0 = fin_cnt;
        bus.in_data = 16'h0055; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        r0 = rdy_cnt;
        repeat (10) @(negedge clk);
        checkOutput("hold.in_ready", 64'(rdy_cnt - r0), 0);
        checkOutput("hold.mem_execute", 64'(exec_cnt - e0), 0);
        checkOutput("hold.writes", 64'(wlog_addr.size() - w0), 0);
        checkOutput("hold.busy", 64'(busy), 1);
        mem_hold = 1'b0;
        sendWord(16'h0055, 1'b1, ok);
        waitDone("hold");
        checkOutput("hold.words_loaded", 64'(words_loaded), 1);
        checkOutput("hold.addr", 64'(wlog_addr[w0]), 5);
        checkOutput("hold.finished", 64'(fin_cnt - f0), 1);

        // Asynchronous reset while the write is being acknowledged.
        pulseStart(3);
        sendWord(16'h1234, 1'b0, ok);
        for (int t = 0; t < 20 && !bus.mem_execute; t++) @(negedge clk);
        @(negedge clk);
        checkOutput("midrst.mem_func_before", 64'(bus.mem_func), 1);
        #2;
        rst = 1'b0;
        #1;
        checkIdleZero("midrst");
        @(negedge clk);
        rst = 1'b1;
        stim_words.delete();
        for (int i = 0; i < 3; i++) stim_words.push_back(DATA_W'(16'h0B00 + i));
        applyStimulus(8, 3, 0, 1'b0, 3, 3, 1'b0, "after_rst");

        // Power drops right after a word is accepted, freezing the pending write strobe.
        trav_delay = 0;
        pulseStart(20);
        e0 = exec_cnt; w0 = wlog_addr.size(); f0 = fin_cnt;
        bus.in_data = 16'h2020; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (bus.in_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        power = 1'b0;
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("power.mem_execute_now", 64'(bus.mem_execute), 0);
        checkOutput("power.frozen_strobes", 64'(exec_cnt - e0), 0);
        checkOutput("power.frozen_writes", 64'(wlog_addr.size() - w0), 0);
        checkOutput("power.write_data_held", 64'(bus.write_data), 64'h2020);
        power = 1'b1;
        waitDone("power");
`ifdef MEM_LOADER_VERIFY_EN
        checkOutput("power.strobes", 64'(exec_cnt - e0), 2);
`else
        checkOutput("power.strobes", 64'(exec_cnt - e0), 1);
`endif
        checkOutput("power.writes", 64'(wlog_addr.size() - w0), 1);
        checkOutput("power.words_loaded", 64'(words_loaded), 1);
        checkOutput("power.finished", 64'(fin_cnt - f0), 1);

`ifdef MEM_LOADER_VERIFY_EN
        // Second read-back comes back corrupted.
        trav_pre = 1'b0;
        corrupt_at = rd_cnt + 1;
        pulseStart(10);
        w0 = wlog_addr.size(); f0 = fin_cnt; r0 = trav_cyc;
        for (int i = 0; i < 3; i++) begin
            sendWord(DATA_W'(16'hC0 + i), i == 2, ok);
            if (!ok) break;
        end
        waitDone("verify");
        checkOutput("verify.error", 64'(error), 1);
        checkOutput("verify.words_loaded", 64'(words_loaded), 1);
        checkOutput("verify.writes", 64'(wlog_addr.size() - w0), 2);
        checkOutput("verify.finished", 64'(fin_cnt - f0), 0);
        checkOutput("verify.trav_cycles", 64'(trav_cyc - r0), 0);
        corrupt_at = -1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
